fpga_program_runner: RTL and testbench

Parametrised successor to the fixed single-program FPGA test harness: a small sequencer that holds a loadable test program, executes it one instruction at a time over a register file, checks in-program assertions and reports `finished`/`success`. It sits at the top of each FPGA test build, between the board clock/reset and the pass/fail LEDs. Data width, register count, program depth and a runaway watchdog are parameters.

---
 rtl/fpga_program_runner.sv | 139 +++++++++++++
 tb/tb_fpga_program_runner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpga_program_runner.sv
// fpga_program_runner: loadable test-program sequencer with a small
// register file, in-program assertions, watchdog and pass/fail report.
module fpga_program_runner #(
   parameter int WIDTH     = 16,
   parameter int REGS      = 8,
   parameter int DEPTH     = 64,
   parameter int MAX_STEPS = 1024,
   localparam int RA = $clog2(REGS),
   localparam int AA = $clog2(DEPTH),
   localparam int IW = 4 + 3*RA + WIDTH,
   localparam int SW = $clog2(MAX_STEPS+1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AA-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          start,
   output logic          busy,
   output logic          finished,
   output logic          success,
   output logic [AA-1:0] fail_ip,
   output logic [SW-1:0] steps
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_LOADI = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_ASEQ  = 4'd4;
   localparam logic [3:0] OP_JNZ   = 4'd5;

   state_t            state;
   logic [IW-1:0]     mem [DEPTH];
   logic [WIDTH-1:0]  r [REGS];
   logic [IW-1:0]     ir;
   logic [AA-1:0]     ip;
   logic              fail;

   logic [3:0]        op;
   logic [RA-1:0]     rd;
   logic [RA-1:0]     ra;
   logic [RA-1:0]     rb;
   logic [WIDTH-1:0]  imm;
   logic [WIDTH-1:0]  va;
   logic [WIDTH-1:0]  vb;
   logic [SW-1:0]     steps_nxt;
   logic              halt;
   logic              bad;
   logic              abort;
   logic              idle_like;

   assign idle_like = (state == IDLE) || (state == DONE);

   // Program store: writable only while no run is in progress.
   always_ff @(posedge clock) begin
      if (prog_we && idle_like)
         mem[prog_addr] <= prog_data;
   end

   // Decode the latched instruction and derive failure/abort conditions.
   always_comb begin
      op        = ir[IW-1 -: 4];
      rd        = ir[IW-5 -: RA];
      ra        = ir[IW-5-RA -: RA];
      rb        = ir[IW-5-2*RA -: RA];
      imm       = ir[WIDTH-1:0];
      va        = r[ra];
      vb        = r[rb];
      steps_nxt = steps + 1'b1;
      halt      = (op == OP_HALT);
      bad       = ((op == OP_ASEQ) && (va != vb)) || (op > OP_JNZ);
      abort     = (steps_nxt == SW'(MAX_STEPS)) && !halt;
   end

   // Sequencer: fetch/execute loop, register file and result reporting.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ir       <= '0;
         ip       <= '0;
         fail     <= 1'b0;
         fail_ip  <= '0;
         busy     <= 1'b0;
         finished <= 1'b0;
         success  <= 1'b0;
         steps    <= '0;
         for (int i = 0; i < REGS; i++)
            r[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  ip       <= '0;
                  steps    <= '0;
                  fail     <= 1'b0;
                  fail_ip  <= '0;
                  finished <= 1'b0;
                  success  <= 1'b0;
                  busy     <= 1'b1;
                  for (int i = 0; i < REGS; i++)
                     r[i] <= '0;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               ir    <= mem[ip];
               state <= EXEC;
            end
            EXEC: begin
               steps <= steps_nxt;
               ip    <= ip + 1'b1;
               state <= FETCH;
               case (op)
                  OP_LOADI: r[rd] <= imm;
                  OP_ADD:   r[rd] <= va + vb;
                  OP_SUB:   r[rd] <= va - vb;
                  OP_JNZ:   if (va != '0) ip <= imm[AA-1:0];
                  default:  ;
               endcase
               if ((bad || abort) && !fail)
                  fail_ip <= ip;
               if (bad || abort)
                  fail <= 1'b1;
               if (halt || abort) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  success  <= halt && !fail;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_program_runner.sv
// tb_fpga_program_runner: directed programs with a scoreboard of
// expected run results, checked when finished rises.
module tb_fpga_program_runner;

   localparam int AA = 6;
   localparam int IW = 29;
   localparam int SW = 5;

   typedef struct {
      string tag;
      int    succ;
      int    fip;
      int    st;
      int    cyc;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          prog_we = 1'b0;
   logic [AA-1:0] prog_addr = '0;
   logic [IW-1:0] prog_data = '0;
   logic          start = 1'b0;
   logic          busy;
   logic          finished;
   logic          success;
   logic [AA-1:0] fail_ip;
   logic [SW-1:0] steps;

   int   passed = 0;
   int   total = 0;
   exp_t sb[$];

   fpga_program_runner #(
      .WIDTH(16), .REGS(8), .DEPTH(64), .MAX_STEPS(16)
   ) dut (
      .clock(clock), .reset(reset), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
      .busy(busy), .finished(finished), .success(success),
      .fail_ip(fail_ip), .steps(steps)
   );

   always #5 clock = ~clock;

   function automatic logic [IW-1:0] ins(int op, int rd, int ra, int rb, int imm);
      return {4'(op), 3'(rd), 3'(ra), 3'(rb), 16'(imm)};
   endfunction

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic wr(int a, logic [IW-1:0] d);
      prog_we = 1'b1;
      prog_addr = AA'(a);
      prog_data = d;
      @(posedge clock); #1;
      prog_we = 1'b0;
   endtask

   task automatic run(string tag, int s, int fip, int st, bit disturb);
      exp_t e;
      int   cyc;
      bit   done;
      sb.push_back('{tag, s, fip, st, 2*st});
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 200) begin
         if (disturb && cyc == 3) begin
            start = 1'b1;
            prog_we = 1'b1;
            prog_addr = AA'(5);
            prog_data = ins(9, 0, 0, 0, 0);
         end
         @(posedge clock); #1;
         cyc++;
         start = 1'b0;
         prog_we = 1'b0;
         if (finished) done = 1'b1;
      end
      chk({tag, "/done"}, int'(done), 1);
      e = sb.pop_front();
      chk({e.tag, "/cycles"}, cyc, e.cyc);
      chk({e.tag, "/success"}, int'(success), e.succ);
      chk({e.tag, "/fail_ip"}, int'(fail_ip), e.fip);
      chk({e.tag, "/steps"}, int'(steps), e.st);
      chk({e.tag, "/busy"}, int'(busy), 0);
   endtask

   task automatic load_basic();
      wr(0, ins(1, 1, 0, 0, 3));
      wr(1, ins(1, 2, 0, 0, 4));
      wr(2, ins(2, 3, 1, 2, 0));
      wr(3, ins(1, 4, 0, 0, 7));
      wr(4, ins(4, 0, 3, 4, 0));
      wr(5, ins(0, 0, 0, 0, 0));
   endtask

   initial begin
      #12;
      chk("rst/busy", int'(busy), 0);
      chk("rst/finished", int'(finished), 0);
      chk("rst/success", int'(success), 0);
      chk("rst/fail_ip", int'(fail_ip), 0);
      chk("rst/steps", int'(steps), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;

      load_basic();
      run("basic", 1, 0, 6, 1'b0);

      wr(0, ins(1, 1, 0, 0, 'hFFFF));
      wr(1, ins(1, 2, 0, 0, 1));
      wr(2, ins(2, 3, 1, 2, 0));
      wr(3, ins(4, 0, 3, 0, 0));
      wr(4, ins(0, 0, 0, 0, 0));
      run("wrap", 1, 0, 5, 1'b0);

      wr(0, ins(1, 1, 0, 0, 3));
      wr(1, ins(2, 1, 1, 1, 0));
      wr(2, ins(1, 2, 0, 0, 6));
      wr(3, ins(4, 0, 1, 2, 0));
      wr(4, ins(0, 0, 0, 0, 0));
      run("add_self", 1, 0, 5, 1'b0);

      wr(0, ins(1, 1, 0, 0, 1));
      wr(1, ins(1, 2, 0, 0, 2));
      wr(2, ins(4, 0, 1, 2, 0));
      wr(3, ins(1, 3, 0, 0, 0));
      wr(4, ins(4, 0, 1, 3, 0));
      wr(5, ins(0, 0, 0, 0, 0));
      run("two_fail", 0, 2, 6, 1'b0);

      wr(0, ins(1, 1, 0, 0, 5));
      wr(1, ins(1, 2, 0, 0, 1));
      wr(2, ins(3, 1, 1, 2, 0));
      wr(3, ins(5, 0, 1, 0, 2));
      wr(4, ins(0, 0, 0, 0, 0));
      run("countdown", 1, 0, 13, 1'b0);

      wr(0, ins(1, 1, 0, 0, 1));
      wr(1, ins(5, 0, 1, 0, 1));
      run("watchdog", 0, 1, 16, 1'b0);

      wr(0, ins(9, 0, 0, 0, 0));
      wr(1, ins(0, 0, 0, 0, 0));
      run("illegal", 0, 0, 2, 1'b0);

      load_basic();
      run("busy_ignore", 1, 0, 6, 1'b1);

      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst/busy", int'(busy), 0);
      chk("midrst/finished", int'(finished), 0);
      chk("midrst/steps", int'(steps), 0);
      chk("midrst/success", int'(success), 0);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("midrst/stay_idle", int'(busy), 0);
      chk("midrst/no_finish", int'(finished), 0);
      run("after_rst", 1, 0, 6, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
